lcd_bus_scheduler: RTL and testbench
====================================

LCD_BUS_SCHEDULER -- requirements
Module: lcd_bus_scheduler

Interface
REQ-001 Parameter EN_HIGH_CYC, default 50000: clk cycles EN is held high per transfer.
REQ-002 Parameter EN_LOW_CYC, default 50000: clk cycles EN is held low after each transfer before the next grant.
REQ-003 Parameter LONG_WAIT_CYC, default 100000: EN-low cycles after a clear/home command, used only when LCD_LONG_WAIT_EN is defined.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req0/req1  input  1  requester 0/1 has a pending LCD transfer.
REQ-007 rs0/rs1  input  1  register select of the pending transfer (0 = command, 1 = character).
REQ-008 data0/data1  input  8  byte of the pending transfer.
REQ-009 ack0/ack1  output  1  one-cycle pulse: the transfer is accepted and its rs/data are latched.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 EN, RW, RS  output  1 each  LCD bus controls; RW is tied to 0 (write-only).
REQ-012 data  output  8  LCD data bus.

Function
REQ-013 States: IDLE, PULSE, WAIT; an encoding of two bits or fewer.
REQ-014 IDLE, at least one req high: grant it, pulse that ack for one cycle, latch its rs/data into RS/data, and go to PULSE on the next edge.
REQ-015 Both req high in IDLE: grant the requester not granted last (round-robin); last_grant resets to 1, so requester 0 wins the first tie.
REQ-016 PULSE: EN = 1 for exactly EN_HIGH_CYC cycles, then WAIT with the counter cleared.
REQ-017 WAIT: EN = 0 for EN_LOW_CYC cycles, or LONG_WAIT_CYC per REQ-026, then IDLE.
REQ-018 RS/data stay stable from grant until the next grant; they never change while EN = 1.
REQ-019 Requesters hold req/rs/data until ack and may drop req or present a new byte the cycle after ack. A req that drops before ack is never granted.
REQ-020 req input changes during PULSE/WAIT have no effect; a new ack is possible at the earliest on the cycle the FSM re-enters IDLE.
REQ-021 Grant-to-next-grant latency = 1 + EN_HIGH_CYC + wait count cycles; back-to-back throughput is one transfer per that period.
REQ-022 Counter width = clog2(max(EN_HIGH_CYC, EN_LOW_CYC, LONG_WAIT_CYC)); the counter never wraps.

Reset
REQ-023 While rst = 1, at every edge: state = IDLE, counter = 0, EN = 0, RS = 0, data = 8'h00, ack0 = ack1 = 0, busy = 0, last_grant = 1.
REQ-024 rst asserted mid-PULSE drops EN on that same edge. The aborted transfer is not re-acked or replayed.
REQ-025 rst has priority over all other inputs on the same edge.

Configuration
REQ-026 With LCD_LONG_WAIT_EN defined, a latched command (RS = 0) of 8'h01, 8'h02 or 8'h03 uses LONG_WAIT_CYC in WAIT. Without the macro, every transfer uses EN_LOW_CYC, and LONG_WAIT_CYC is unused.

Structure
REQ-027 Package lcd_pkg holds the state enum, the LCD command constants (CLEAR = 8'h01, HOME = 8'h02, ENTRY_RIGHT = 8'h06, DISP_ON_CUR = 8'h0E, FUNC_2LINE = 8'h38, CUR_LEFT = 8'h10) and the default timing constants.
REQ-028 One sub-module, lcd_rr_arbiter: a 2-way round-robin with a last_grant register and a one-hot grant output. Timing and the FSM stay in the top.

Verification (benches use EN_HIGH_CYC = 4, EN_LOW_CYC = 3, LONG_WAIT_CYC = 10)
REQ-029 req0 = 1, rs0 = 0, data0 = 8'h38 from reset -> ack0 for one cycle; EN high for 4 cycles with data = 8'h38, RS = 0; EN low 3 cycles; busy low after 8 cycles total.
REQ-030 req0 and req1 held high continuously (data0 = 8'h41, data1 = 8'h42, RS = 1) -> grants alternate 0,1,0,1, and data sequence is 41,42,41,42.
REQ-031 Command 8'h01 -> WAIT lasts 10 cycles with LCD_LONG_WAIT_EN and 3 without; character 8'h01 with RS = 1 always waits 3.
REQ-032 rst pulsed on the 2nd PULSE cycle -> EN = 0 and busy = 0 next edge, no ack; a new req0 is acked on the first cycle after rst releases.
REQ-033 req1 raised and then dropped during WAIT -> no ack1; FSM returns to IDLE and stays there, with EN = 0 throughout.
REQ-034 Assertion check on every test: data and RS never change while EN = 1, and RW = 0 always.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD bus scheduler: FSM state encoding,
// HD44780-style command bytes and the default bus timing.
package lcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StPulse = 2'b01,
        StWait  = 2'b10
    } state_e;

    // Common LCD command bytes
    localparam logic [7:0] CLEAR       = 8'h01;
    localparam logic [7:0] HOME        = 8'h02;
    localparam logic [7:0] HOME_ALT    = 8'h03; // low bit is don't-care for HOME
    localparam logic [7:0] ENTRY_RIGHT = 8'h06;
    localparam logic [7:0] DISP_ON_CUR = 8'h0E;
    localparam logic [7:0] FUNC_2LINE  = 8'h38;
    localparam logic [7:0] CUR_LEFT    = 8'h10;

    // Default timing in clk cycles
    localparam int unsigned DEF_EN_HIGH_CYC   = 50000;
    localparam int unsigned DEF_EN_LOW_CYC    = 50000;
    localparam int unsigned DEF_LONG_WAIT_CYC = 100000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter. The requester not granted last wins a tie;
// last_grant only moves when the grant is actually taken.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    logic last_grant_q, last_grant_d;

    // One-hot grant: single requester wins outright, a tie goes to the other side
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
        end
    end

    // Remember the winner only on an accepted grant
    always_comb begin
        last_grant_d = last_grant_q;
        if (take && (gnt != 2'b00)) begin
            last_grant_d = gnt[1];
        end
    end

    // Reset to 1 so requester 0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Shares one write-only LCD bus between two requesters. Each accepted transfer
// drives EN high for EN_HIGH_CYC cycles, then holds EN low for the settle time
// before the next grant. Define LCD_LONG_WAIT_EN to give clear/home commands
// the longer LONG_WAIT_CYC settle time.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int unsigned EN_HIGH_CYC   = DEF_EN_HIGH_CYC,
    parameter int unsigned EN_LOW_CYC    = DEF_EN_LOW_CYC,
    parameter int unsigned LONG_WAIT_CYC = DEF_LONG_WAIT_CYC
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       rs0,
    input  logic       rs1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       ack0,
    output logic       ack1,
    output logic       busy,
    output logic       EN,
    output logic       RW,
    output logic       RS,
    output logic [7:0] data
);

    localparam int unsigned MaxCyc = max3(EN_HIGH_CYC, EN_LOW_CYC, LONG_WAIT_CYC);
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    // Terminal counts; the counter stops at these and never wraps
    localparam logic [CntW-1:0] HighLast = CntW'(EN_HIGH_CYC - 1);
    localparam logic [CntW-1:0] LowLast  = CntW'(EN_LOW_CYC - 1);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_WAIT_CYC - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic [1:0]      gnt;
    logic            take;
    logic            long_wait;
    logic [CntW-1:0] wait_last;

    lcd_rr_arbiter u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  ({req1, req0}),
        .take (take),
        .gnt  (gnt)
    );

    // Pick the settle time from the latched transfer
    always_comb begin
`ifdef LCD_LONG_WAIT_EN
        long_wait = !rs_q && ((data_q == CLEAR) || (data_q == HOME) || (data_q == HOME_ALT));
`else
        long_wait = 1'b0;
`endif
        wait_last = long_wait ? LongLast : LowLast;
    end

    // Next-state, counter and latch control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                // rst gates the grant so no ack escapes while reset is held
                if (!rst && (gnt != 2'b00)) begin
                    take    = 1'b1;
                    state_d = StPulse;
                    cnt_d   = '0;
                    rs_d    = gnt[1] ? rs1 : rs0;
                    data_d  = gnt[1] ? data1 : data0;
                end
            end
            StPulse: begin
                if (cnt_q == HighLast) begin
                    state_d = StWait;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (cnt_q == wait_last) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and bus latches
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    // Outputs decode directly from registered state
    always_comb begin
        ack0 = take & gnt[0];
        ack1 = take & gnt[1];
        busy = (state_q != StIdle);
        EN   = (state_q == StPulse);
        RW   = 1'b0;
        RS   = rs_q;
        data = data_q;
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Scoreboard bench for lcd_bus_scheduler with short timing (4/3/10).
module tb_lcd_bus_scheduler;

    localparam int unsigned HIGH = 4;
    localparam int unsigned LOW  = 3;
    localparam int unsigned LONG = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, rs0, rs1;
    logic [7:0] data0, data1;
    logic       ack0, ack1, busy, EN, RW, RS;
    logic [7:0] data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         port;
        logic       rs;
        logic [7:0] d;
        int         wt;
    } exp_t;

    exp_t q[$];

    lcd_bus_scheduler #(
        .EN_HIGH_CYC   (HIGH),
        .EN_LOW_CYC    (LOW),
        .LONG_WAIT_CYC (LONG)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req0  (req0),
        .req1  (req1),
        .rs0   (rs0),
        .rs1   (rs1),
        .data0 (data0),
        .data1 (data1),
        .ack0  (ack0),
        .ack1  (ack1),
        .busy  (busy),
        .EN    (EN),
        .RW    (RW),
        .RS    (RS),
        .data  (data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int exp_wait(input logic rs, input logic [7:0] d);
`ifdef LCD_LONG_WAIT_EN
        if (!rs && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return LONG;
`endif
        return LOW;
    endfunction

    task automatic push(input int port, input logic rs, input logic [7:0] d);
        exp_t e;
        e.port = port;
        e.rs   = rs;
        e.d    = d;
        e.wt   = exp_wait(rs, d);
        q.push_back(e);
    endtask

    // Wait (bounded) for the ack of one port, then drop that request after the grant edge
    task automatic wait_ack_drop(input int port);
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((port == 0 && ack0) || (port == 1 && ack1)) begin
                seen = 1;
                break;
            end
        end
        check("ack_timeout", {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) req0 = 1'b0;
        else req1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                seen = 1;
                break;
            end
        end
        check("idle_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic send(input int port, input logic rs, input logic [7:0] d);
        push(port, rs, d);
        @(posedge clk);
        #1;
        if (port == 0) begin
            req0 = 1'b1; rs0 = rs; data0 = d;
        end else begin
            req1 = 1'b1; rs1 = rs; data1 = d;
        end
        wait_ack_drop(port);
        wait_idle();
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: pop on every ack, then check latched bus and EN high/low lengths
    initial begin
        exp_t cur;
        bit   active = 0;
        bit   pend = 0;
        int   hcnt = 0;
        int   wcnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("ack_in_reset", {30'd0, ack1, ack0}, 32'd0);
                active = 0;
                pend   = 0;
            end else begin
                if (active && !busy) begin
                    check("en_high_cycles", hcnt, HIGH);
                    check("wait_cycles", wcnt, cur.wt);
                    active = 0;
                end
                if (ack0 || ack1) begin
                    if (q.size() == 0) begin
                        check("unexpected_ack", {30'd0, ack1, ack0}, 32'd0);
                    end else begin
                        cur = q.pop_front();
                        check("ack_port", {30'd0, ack1, ack0}, (cur.port == 0) ? 32'd1 : 32'd2);
                        active = 1;
                        pend   = 1;
                        hcnt   = 0;
                        wcnt   = 0;
                    end
                end else if (active) begin
                    if (pend) begin
                        check("latched_rs", {31'd0, RS}, {31'd0, cur.rs});
                        check("latched_data", {24'd0, data}, {24'd0, cur.d});
                        pend = 0;
                    end
                    if (EN) hcnt++;
                    else wcnt++;
                end
            end
        end
    end

    // Bus invariants: RS/data frozen while EN is high, RW always low
    initial begin
        logic       en_p = 1'b0;
        logic       rs_p = 1'b0;
        logic [7:0] d_p  = 8'h00;
        forever begin
            @(negedge clk);
            if (EN && en_p) begin
                check("stable_while_en", {23'd0, RS, data}, {23'd0, rs_p, d_p});
            end
            if (RW !== 1'b0) check("rw_low", {31'd0, RW}, 32'd0);
            en_p = EN;
            rs_p = RS;
            d_p  = data;
        end
    end

    // Stimulus
    initial begin
        int  n;
        int  en_seen;
        int  ack1_seen;
        bit  found;
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rs0 = 1'b0; rs1 = 1'b0;
        data0 = 8'h00; data1 = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_en", {31'd0, EN}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rs_data", {23'd0, RS, data}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single command transfer
        send(0, 1'b0, 8'h38);

        // Continuous tie after reset: 0,1,0,1
        pulse_reset();
        push(0, 1'b1, 8'h41);
        push(1, 1'b1, 8'h42);
        push(0, 1'b1, 8'h41);
        push(1, 1'b1, 8'h42);
        req0 = 1'b1; rs0 = 1'b1; data0 = 8'h41;
        req1 = 1'b1; rs1 = 1'b1; data1 = 8'h42;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ack0 || ack1) n++;
            if (n == 4) break;
        end
        check("rr_ack_count", n, 4);
        @(posedge clk);
        #1 req0 = 1'b0; req1 = 1'b0;
        wait_idle();

        // Long-wait candidates versus characters and short commands
        send(0, 1'b0, 8'h01);
        send(1, 1'b1, 8'h01);
        send(1, 1'b0, 8'h02);
        send(0, 1'b0, 8'h06);

        // Reset during the second PULSE cycle aborts the transfer
        push(0, 1'b0, 8'h0E);
        @(posedge clk);
        #1 req0 = 1'b1; rs0 = 1'b0; data0 = 8'h0E;
        wait_ack_drop(0);
        @(posedge clk);
        #1 rst = 1'b1;
        req0 = 1'b1; rs0 = 1'b0; data0 = 8'h10;
        push(0, 1'b0, 8'h10);
        @(posedge clk);
        #1;
        check("abort_en", {31'd0, EN}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ack", {30'd0, ack1, ack0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ack0", {31'd0, ack0}, 32'd1);
        @(posedge clk);
        #1 req0 = 1'b0;
        wait_idle();

        // req1 pulsed during WAIT must be ignored
        push(0, 1'b0, 8'h06);
        @(posedge clk);
        #1 req0 = 1'b1; rs0 = 1'b0; data0 = 8'h06;
        wait_ack_drop(0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!EN) begin
                found = 1;
                break;
            end
        end
        check("reach_wait", {31'd0, found}, 32'd1);
        @(posedge clk);
        #1 req1 = 1'b1; rs1 = 1'b1; data1 = 8'h55;
        @(posedge clk);
        #1 req1 = 1'b0;
        en_seen = 0;
        ack1_seen = 0;
        repeat (14) begin
            @(negedge clk);
            if (EN) en_seen++;
            if (ack1) ack1_seen++;
        end
        check("drop_no_ack1", ack1_seen, 0);
        check("drop_en_low", en_seen, 0);
        check("drop_idle", {31'd0, busy}, 32'd0);

        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
